// File: rtl/sram_arbiter_if.sv
// Requester and SRAM bus bundle for sram_arbiter.
// slave: the arbiter's view. master: the view of the requesters and SRAM.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
);
  // Requester side; slice 0 is port A, slice 1 is port B
  logic [1:0]          req;
  logic [1:0]          we;
  logic [2*ADDR_W-1:0] addr1;
  logic [2*ADDR_W-1:0] addr2;
  logic [2*DATA_W-1:0] wdata1;
  logic [2*DATA_W-1:0] wdata2;
  logic [1:0]          ack;
  logic [DATA_W-1:0]   rdata1;
  logic [DATA_W-1:0]   rdata2;
  logic                busy;

  // SRAM side
  logic                mem_cs_n;
  logic                mem_oe;
  logic                mem_rw;
  logic [ADDR_W-1:0]   mem_addr1;
  logic [ADDR_W-1:0]   mem_addr2;
  logic [DATA_W-1:0]   mem_wdata1;
  logic [DATA_W-1:0]   mem_wdata2;
  logic [DATA_W-1:0]   mem_rdata1;
  logic [DATA_W-1:0]   mem_rdata2;

  modport slave (
    input  req, we, addr1, addr2, wdata1, wdata2, mem_rdata1, mem_rdata2,
    output ack, rdata1, rdata2, busy,
    output mem_cs_n, mem_oe, mem_rw, mem_addr1, mem_addr2, mem_wdata1, mem_wdata2
  );

  modport master (
    output req, we, addr1, addr2, wdata1, wdata2, mem_rdata1, mem_rdata2,
    input  ack, rdata1, rdata2, busy,
    input  mem_cs_n, mem_oe, mem_rw, mem_addr1, mem_addr2, mem_wdata1, mem_wdata2
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a dual-lane asynchronous SRAM.
// One transaction at a time: a read holds the chip in read for READ_CYCLES
// cycles and captures data on the last one; a write runs setup/strobe/hold.
// Each transaction ends with a one-cycle ack to the granted port.
// Define SRAM_ARB_FIXED_PRIO_EN to make port A win every simultaneous
// request; by default simultaneous requests are served round-robin.
module sram_arbiter #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned READ_CYCLES = 3
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(READ_CYCLES);
  localparam logic [CntW-1:0] RdLast = CntW'(READ_CYCLES - 1);
  localparam logic [CntW-1:0] StrobeLast = CntW'(1);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_STROBE, WR_HOLD, ACK} state_e;

  state_e            stateQ, stateD;
  logic [CntW-1:0]   cntQ, cntD;
  logic              lastGrantQ, lastGrantD;
  logic              grantQ, grantD;
  logic              grantSel;
  logic [ADDR_W-1:0] addr1Q, addr1D, addr2Q, addr2D;
  logic [DATA_W-1:0] wdata1Q, wdata1D, wdata2Q, wdata2D;
  logic [DATA_W-1:0] rdata1Q, rdata1D, rdata2Q, rdata2D;

  // Choose which port to serve should a request be accepted this cycle.
  always_comb begin
    grantSel = 1'b0;
    if (bus.req == 2'b11) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      grantSel = 1'b0;
`else
      grantSel = ~lastGrantQ;
`endif
    end else begin
      grantSel = bus.req[1];
    end
  end

  // Next-state logic: arbitration in IDLE, phase timing, read capture.
  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    lastGrantD = lastGrantQ;
    grantD     = grantQ;
    addr1D     = addr1Q;
    addr2D     = addr2Q;
    wdata1D    = wdata1Q;
    wdata2D    = wdata2Q;
    rdata1D    = rdata1Q;
    rdata2D    = rdata2Q;
    unique case (stateQ)
      IDLE: begin
        if (|bus.req) begin
          grantD     = grantSel;
          lastGrantD = grantSel;
          cntD       = '0;
          addr1D     = grantSel ? bus.addr1[2*ADDR_W-1:ADDR_W] : bus.addr1[ADDR_W-1:0];
          addr2D     = grantSel ? bus.addr2[2*ADDR_W-1:ADDR_W] : bus.addr2[ADDR_W-1:0];
          wdata1D    = grantSel ? bus.wdata1[2*DATA_W-1:DATA_W] : bus.wdata1[DATA_W-1:0];
          wdata2D    = grantSel ? bus.wdata2[2*DATA_W-1:DATA_W] : bus.wdata2[DATA_W-1:0];
          stateD     = (grantSel ? bus.we[1] : bus.we[0]) ? WR_SETUP : RD;
        end
      end
      RD: begin
        if (cntQ == RdLast) begin
          rdata1D = bus.mem_rdata1;
          rdata2D = bus.mem_rdata2;
          stateD  = ACK;
        end else begin
          cntD = cntQ + CntW'(1);
        end
      end
      WR_SETUP: begin
        cntD   = '0;
        stateD = WR_STROBE;
      end
      WR_STROBE: begin
        if (cntQ == StrobeLast) begin
          stateD = WR_HOLD;
        end else begin
          cntD = cntQ + CntW'(1);
        end
      end
      WR_HOLD: stateD = ACK;
      ACK:     stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // SRAM control and ack decoded from the current state.
  always_comb begin
    bus.mem_cs_n   = 1'b1;
    bus.mem_oe     = 1'b0;
    bus.mem_rw     = 1'b0;
    bus.mem_wdata1 = '0;
    bus.mem_wdata2 = '0;
    bus.ack        = 2'b00;
    unique case (stateQ)
      RD: bus.mem_cs_n = 1'b0;
      WR_SETUP, WR_STROBE, WR_HOLD: begin
        bus.mem_cs_n   = 1'b0;
        bus.mem_oe     = 1'b1;
        bus.mem_rw     = (stateQ == WR_STROBE);
        bus.mem_wdata1 = wdata1Q;
        bus.mem_wdata2 = wdata2Q;
      end
      ACK:     bus.ack = grantQ ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  assign bus.busy      = (stateQ != IDLE);
  assign bus.mem_addr1 = addr1Q;
  assign bus.mem_addr2 = addr2Q;
  assign bus.rdata1    = rdata1Q;
  assign bus.rdata2    = rdata2Q;

  // State and datapath registers; reset drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= IDLE;
      cntQ       <= '0;
      lastGrantQ <= 1'b1;  // port B, so port A wins the first contest
      grantQ     <= 1'b0;
      addr1Q     <= '0;
      addr2Q     <= '0;
      wdata1Q    <= '0;
      wdata2Q    <= '0;
      rdata1Q    <= '0;
      rdata2Q    <= '0;
    end else begin
      stateQ     <= stateD;
      cntQ       <= cntD;
      lastGrantQ <= lastGrantD;
      grantQ     <= grantD;
      addr1Q     <= addr1D;
      addr2Q     <= addr2D;
      wdata1Q    <= wdata1D;
      wdata2Q    <= wdata2D;
      rdata1Q    <= rdata1D;
      rdata2Q    <= rdata2D;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural dual-lane SRAM.
`timescale 1ns/1ps
module tb_sram_arbiter;
  localparam int unsigned ADDR_W      = 11;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned READ_CYCLES = 3;
  localparam int RdLat = READ_CYCLES + 1;
  localparam int WrLat = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .READ_CYCLES(READ_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // SRAM model: unwritten locations return a fixed address-derived pattern
  logic [15:0] sram1 [2048];
  logic [15:0] sram2 [2048];
  bit          written1 [2048];
  bit          written2 [2048];

  function automatic logic [15:0] initPat1(input logic [10:0] a);
    if (a == 11'h005) return 16'h1234;
    return {5'b0, a} ^ 16'hC3C3;
  endfunction

  function automatic logic [15:0] initPat2(input logic [10:0] a);
    if (a == 11'h7FA) return 16'hABCD;
    return ~{a, 5'b0};
  endfunction

  always @(posedge clk) begin
    if (!bus.mem_cs_n && bus.mem_oe && bus.mem_rw) begin
      sram1[bus.mem_addr1]    <= bus.mem_wdata1;
      sram2[bus.mem_addr2]    <= bus.mem_wdata2;
      written1[bus.mem_addr1] <= 1'b1;
      written2[bus.mem_addr2] <= 1'b1;
    end
  end

  assign bus.mem_rdata1 = (!bus.mem_cs_n && !bus.mem_oe) ?
      (written1[bus.mem_addr1] ? sram1[bus.mem_addr1] : initPat1(bus.mem_addr1)) : 16'hDEAD;
  assign bus.mem_rdata2 = (!bus.mem_cs_n && !bus.mem_oe) ?
      (written2[bus.mem_addr2] ? sram2[bus.mem_addr2] : initPat2(bus.mem_addr2)) : 16'hDEAD;

  int passCnt = 0;
  int totalCnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0]  ack;
    logic [15:0] rd1;
    logic [15:0] rd2;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  // Per-port request fields, index 0 = A, 1 = B
  logic        pWe [2];
  logic [10:0] pA1 [2];
  logic [10:0] pA2 [2];
  logic [15:0] pW1 [2];
  logic [15:0] pW2 [2];

  task automatic applyPorts();
    bus.we     = {pWe[1], pWe[0]};
    bus.addr1  = {pA1[1], pA1[0]};
    bus.addr2  = {pA2[1], pA2[0]};
    bus.wdata1 = {pW1[1], pW1[0]};
    bus.wdata2 = {pW2[1], pW2[0]};
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, " idle ctl"}, {bus.mem_cs_n, bus.mem_oe, bus.mem_rw, bus.busy, bus.ack},
        {1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
    chk({tag, " idle wdata"}, {bus.mem_wdata1, bus.mem_wdata2}, 32'h0);
  endtask

  // Called at posedge+1 of an IDLE cycle; that cycle is cycle 0.
  task automatic runTxn(input logic [1:0] reqVec, input logic expPort, input logic [1:0] eAck,
                        input int eLat, input logic [15:0] eRd1, input logic [15:0] eRd2,
                        input int dropCycle, input bit keepReq, input string tag);
    exp_t e;
    exp_t got;
    bit   seen;
    logic we;
    we    = pWe[expPort];
    e.ack = eAck;
    e.rd1 = eRd1;
    e.rd2 = eRd2;
    e.lat = eLat;
    sbq.push_back(e);
    applyPorts();
    bus.req = reqVec;
    @(negedge clk);
    chkIdle({tag, " c0"});
    seen = 1'b0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (k == dropCycle) bus.req[expPort] = 1'b0;
      @(negedge clk);
      if (bus.ack != 2'b00) begin
        seen = 1'b1;
        got  = sbq.pop_front();
        chk({tag, " ack"}, bus.ack, got.ack);
        chk({tag, " latency"}, k, got.lat);
        chk({tag, " rdata"}, {bus.rdata1, bus.rdata2}, {got.rd1, got.rd2});
        chk({tag, " ack ctl"}, {bus.mem_cs_n, bus.mem_rw, bus.busy}, 3'b101);
      end else begin
        chk($sformatf("%s c%0d ctl", tag, k), {bus.mem_cs_n, bus.mem_oe, bus.mem_rw, bus.busy},
            {1'b0, we, we && (k == 2 || k == 3), 1'b1});
        chk($sformatf("%s c%0d addr", tag, k), {bus.mem_addr1, bus.mem_addr2},
            {pA1[expPort], pA2[expPort]});
        chk($sformatf("%s c%0d wdata", tag, k), {bus.mem_wdata1, bus.mem_wdata2},
            we ? {pW1[expPort], pW2[expPort]} : 32'h0);
      end
    end
    if (!seen) begin
      totalCnt++;
      $display("FAIL %s timeout: no ack in 12 cycles, expected ack %b", tag, e.ack);
      got = sbq.pop_front();
    end
    @(posedge clk);
    #1;
    if (!keepReq) begin
      bus.req = 2'b00;
      @(negedge clk);
      chkIdle({tag, " after"});
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [10:0] a1;
    logic [10:0] a2;
    logic [15:0] w1;
    logic [15:0] w2;
    int          drop;
    logic [1:0]  eAck;
    int          eLat;
    logic [15:0] eRd1;
    logic [15:0] eRd2;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic o;
    bit   ackSeen;
    tbl[0] = '{1'b0, 1'b0, 11'h005, 11'h7FA, 16'h0000, 16'h0000, 0, 2'b01, RdLat, 16'h1234, 16'hABCD};
    tbl[1] = '{1'b1, 1'b1, 11'h010, 11'h020, 16'h00FF, 16'h5A5A, 0, 2'b10, WrLat, 16'h1234, 16'hABCD};
    tbl[2] = '{1'b0, 1'b0, 11'h010, 11'h020, 16'h0000, 16'h0000, 0, 2'b01, RdLat, 16'h00FF, 16'h5A5A};
    tbl[3] = '{1'b0, 1'b1, 11'h7FF, 11'h000, 16'hFFFF, 16'h0001, 0, 2'b01, WrLat, 16'h00FF, 16'h5A5A};
    tbl[4] = '{1'b1, 1'b0, 11'h7FF, 11'h000, 16'h0000, 16'h0000, 0, 2'b10, RdLat, 16'hFFFF, 16'h0001};
    tbl[5] = '{1'b1, 1'b1, 11'h005, 11'h7FA, 16'h0000, 16'h8000, 0, 2'b10, WrLat, 16'hFFFF, 16'h0001};
    tbl[6] = '{1'b0, 1'b0, 11'h005, 11'h7FA, 16'h0000, 16'h0000, 2, 2'b01, RdLat, 16'h0000, 16'h8000};
    tbl[7] = '{1'b1, 1'b0, 11'h011, 11'h7F9, 16'h0000, 16'h0000, 0, 2'b10, RdLat, 16'hC3D2, 16'h00DF};

    // Reset with both requests and busy inputs present: reset must dominate
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      pWe[p] = 1'b1;
      pA1[p] = 11'h3A5;
      pA2[p] = 11'h15A;
      pW1[p] = 16'hBEEF;
      pW2[p] = 16'hCAFE;
    end
    applyPorts();
    bus.req = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chkIdle("reset");
    chk("reset addr", {bus.mem_addr1, bus.mem_addr2}, 22'h0);
    chk("reset rdata", {bus.rdata1, bus.rdata2}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req = 2'b00;
    @(posedge clk);
    #1;

    // Table of single-port transactions; the idle port carries junk fields
    for (int i = 0; i < 8; i++) begin
      o = ~tbl[i].port;
      pWe[tbl[i].port] = tbl[i].we;
      pA1[tbl[i].port] = tbl[i].a1;
      pA2[tbl[i].port] = tbl[i].a2;
      pW1[tbl[i].port] = tbl[i].w1;
      pW2[tbl[i].port] = tbl[i].w2;
      pWe[o] = ~tbl[i].we;
      pA1[o] = ~tbl[i].a1;
      pA2[o] = ~tbl[i].a2;
      pW1[o] = ~tbl[i].w1;
      pW2[o] = ~tbl[i].w2;
      runTxn(tbl[i].port ? 2'b10 : 2'b01, tbl[i].port, tbl[i].eAck, tbl[i].eLat,
             tbl[i].eRd1, tbl[i].eRd2, tbl[i].drop, 1'b0, $sformatf("vec%0d", i));
    end

    // Reset during the write strobe drops the transaction
    pWe[1] = 1'b1;
    pA1[1] = 11'h100;
    pA2[1] = 11'h200;
    pW1[1] = 16'h1111;
    pW2[1] = 16'h2222;
    applyPorts();
    bus.req = 2'b10;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst-wr strobe", {bus.mem_cs_n, bus.mem_oe, bus.mem_rw, bus.busy}, 4'b0111);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req = 2'b00;
    @(negedge clk);
    chk("rst-wr ctl", {bus.mem_cs_n, bus.mem_rw, bus.busy, bus.ack}, 5'b10000);
    chk("rst-wr rdata", {bus.rdata1, bus.rdata2}, 32'h0);
    chk("rst-wr addr", {bus.mem_addr1, bus.mem_addr2}, 22'h0);
    ackSeen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.ack != 2'b00) ackSeen = 1'b1;
    end
    chk("rst-wr no ack", ackSeen, 1'b0);
    @(posedge clk);
    #1;

    // Both ports requesting continuously, then a fresh contest
    pWe[0] = 1'b0;
    pA1[0] = 11'h010;
    pA2[0] = 11'h020;
    pWe[1] = 1'b0;
    pA1[1] = 11'h7FF;
    pA2[1] = 11'h000;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    runTxn(2'b11, 1'b0, 2'b01, RdLat, 16'h00FF, 16'h5A5A, 0, 1'b1, "arb1");
    runTxn(2'b11, 1'b0, 2'b01, RdLat, 16'h00FF, 16'h5A5A, 0, 1'b1, "arb2");
    runTxn(2'b11, 1'b0, 2'b01, RdLat, 16'h00FF, 16'h5A5A, 0, 1'b0, "arb3");
    runTxn(2'b11, 1'b0, 2'b01, RdLat, 16'h00FF, 16'h5A5A, 0, 1'b0, "arb4");
`else
    runTxn(2'b11, 1'b0, 2'b01, RdLat, 16'h00FF, 16'h5A5A, 0, 1'b1, "arb1");
    runTxn(2'b11, 1'b1, 2'b10, RdLat, 16'hFFFF, 16'h0001, 0, 1'b1, "arb2");
    runTxn(2'b11, 1'b0, 2'b01, RdLat, 16'h00FF, 16'h5A5A, 0, 1'b0, "arb3");
    runTxn(2'b11, 1'b1, 2'b10, RdLat, 16'hFFFF, 16'h0001, 0, 1'b0, "arb4");
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passCnt, totalCnt);
    $fatal(1, "watchdog");
  end

endmodule
